wb_arbiter: RTL and testbench

Writeback arbiter between the three ALU wrappers and the shared result path. It buffers each ALU's completion in a small per-source queue and grants up to two register results per cycle onto result buses bus0/bus1, round-robin across sources. It forwards at most one memory-op result per cycle to the LSQ. It back-pressures each ALU when that ALU's queue is full, and it clears all queues on flush.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_src_fifo.sv | 45 ++++
 rtl/wb_arbiter.sv | 100 ++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, bus field positions and the queued writeback entry type.
package wb_arb_pkg;
  localparam int NUM_SRC   = 3;
  localparam int WB_DEPTH  = 2;
  localparam int WB_DATA_W = 32;
  localparam int WB_TAG_W  = 6;
  localparam int WB_PC_W   = 12;
  localparam int BUS_WIDTH = 1 + WB_PC_W + WB_DATA_W + 2 * WB_TAG_W;
  localparam int BUS_ROB   = 0;
  localparam int BUS_RD    = BUS_ROB + WB_TAG_W;
  localparam int BUS_RES   = BUS_RD + WB_TAG_W;
  localparam int BUS_PC    = BUS_RES + WB_DATA_W;
  localparam int BUS_VALID = BUS_PC + WB_PC_W;
  typedef struct packed {
    logic                 mem;
    logic [WB_PC_W-1:0]   pc;
    logic [WB_DATA_W-1:0] res;
    logic [WB_TAG_W-1:0]  rd;
    logic [WB_TAG_W-1:0]  rob;
  } wb_entry_t;
  function automatic logic [1:0] rr_add(input logic [1:0] p, input int k);
    return 2'((int'(p) + k) % NUM_SRC);
  endfunction
endpackage

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: DEPTH-entry circular queue of writeback entries with synchronous flush.
module wb_src_fifo
  import wb_arb_pkg::*;
#(
  parameter int  DEPTH = WB_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  wb_entry_t     i_data,
  input  logic          i_pop,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output logic          o_ready
);
  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  // Ready comes only from the registered count: a full queue refuses input even while popping.
  assign o_ready = r_count < CW'(DEPTH);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rp];
  assign w_push  = i_push & o_ready & ~i_flush;
  assign w_pop   = i_pop & (r_count != '0) & ~i_flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_push ? (r_wp == PW'(DEPTH - 1) ? '0 : r_wp + 1'b1) : r_wp;
      r_rp    <= w_pop ? (r_rp == PW'(DEPTH - 1) ? '0 : r_rp + 1'b1) : r_rp;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-ALU writeback queues feeding two round-robin result buses and one LSQ port.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int  DEPTH  = WB_DEPTH,
  parameter int  DATA_W = WB_DATA_W,
  parameter int  TAG_W  = WB_TAG_W,
  parameter int  PC_W   = WB_PC_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_mem,
  input  logic [NUM_SRC*DATA_W-1:0] src_res,
  input  logic [NUM_SRC*TAG_W-1:0]  src_rd,
  input  logic [NUM_SRC*TAG_W-1:0]  src_rob,
  input  logic [NUM_SRC*PC_W-1:0]   src_pc,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [BUS_WIDTH-1:0]      bus0,
  output logic [BUS_WIDTH-1:0]      bus1,
  input  logic                      mem_ready,
  output logic                      mem_valid,
  output logic [DATA_W-1:0]         mem_res,
  output logic [TAG_W-1:0]          mem_rob
);
  wb_entry_t            w_head  [NUM_SRC];
  logic [CW-1:0]        w_count [NUM_SRC];
  logic [1:0]           w_scan  [NUM_SRC];
  logic [NUM_SRC-1:0]   w_pop;
  logic [1:0]           r_rr, w_rr_nxt, w_b0_s, w_b1_s, w_m_s;
  logic                 w_b0_v, w_b1_v, w_m_v, w_m_seen;
  logic [BUS_WIDTH-1:0] w_bus0, w_bus1;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_entry_t w_in;
    assign w_in = '{mem: src_mem[g], pc: src_pc[g*PC_W +: PC_W], res: src_res[g*DATA_W +: DATA_W],
                    rd: src_rd[g*TAG_W +: TAG_W], rob: src_rob[g*TAG_W +: TAG_W]};
    assign w_scan[g] = rr_add(r_rr, g);
    wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (src_valid[g]),
      .i_data  (w_in),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g]),
      .o_ready (src_ready[g])
    );
  end
  // Only the first mem head in scan order may go to the LSQ, and only when it is ready.
  always_comb begin
    w_b0_v   = 1'b0;
    w_b1_v   = 1'b0;
    w_m_v    = 1'b0;
    w_m_seen = 1'b0;
    w_b0_s   = '0;
    w_b1_s   = '0;
    w_m_s    = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (w_count[w_scan[k]] != '0) begin
        if (w_head[w_scan[k]].mem) begin
          if (!w_m_seen) begin
            w_m_seen = 1'b1;
            w_m_v    = mem_ready;
            w_m_s    = w_scan[k];
          end
        end else if (!w_b0_v) begin
          w_b0_v = 1'b1;
          w_b0_s = w_scan[k];
        end else if (!w_b1_v) begin
          w_b1_v = 1'b1;
          w_b1_s = w_scan[k];
        end
      end
  end
  assign w_pop    = (NUM_SRC'(w_b0_v) << w_b0_s) | (NUM_SRC'(w_b1_v) << w_b1_s) | (NUM_SRC'(w_m_v) << w_m_s);
  assign w_rr_nxt = w_b1_v ? rr_add(w_b1_s, 1) : w_b0_v ? rr_add(w_b0_s, 1) : r_rr;
  assign w_bus0   = w_b0_v ? {1'b1, w_head[w_b0_s].pc, w_head[w_b0_s].res, w_head[w_b0_s].rd, w_head[w_b0_s].rob} : '0;
  assign w_bus1   = w_b1_v ? {1'b1, w_head[w_b1_s].pc, w_head[w_b1_s].res, w_head[w_b1_s].rd, w_head[w_b1_s].rob} : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rr      <= '0;
      bus0      <= '0;
      bus1      <= '0;
      mem_valid <= 1'b0;
      mem_res   <= '0;
      mem_rob   <= '0;
    end else begin
      r_rr      <= flush ? '0 : w_rr_nxt;
      bus0      <= flush ? '0 : w_bus0;
      bus1      <= flush ? '0 : w_bus1;
      mem_valid <= w_m_v & ~flush;
      mem_res   <= (w_m_v && !flush) ? w_head[w_m_s].res : '0;
      mem_rob   <= (w_m_v && !flush) ? w_head[w_m_s].rob : '0;
    end
  // Presenting a result to a full queue drops it; flag the producer's mistake.
  a_no_drop: assert property (@(posedge clk) disable iff (rst || flush) (src_valid & ~src_ready) == '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arb_pkg::*;
  localparam int DEPTH = 2;
  typedef struct {
    logic        mem;
    logic [11:0] pc;
    logic [31:0] res;
    logic [5:0]  rd;
    logic [5:0]  rob;
  } ent_t;

  logic clk = 0, rst = 1, flush = 0, mem_ready = 0;
  logic [2:0]  src_valid = 0, src_mem = 0, src_ready;
  logic [95:0] src_res = 0;
  logic [17:0] src_rd = 0, src_rob = 0;
  logic [35:0] src_pc = 0;
  logic [BUS_WIDTH-1:0] bus0, bus1;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic [5:0]  mem_rob;

  logic [31:0] d_res [3];
  logic [5:0]  d_rd  [3];
  logic [5:0]  d_rob [3];
  logic [11:0] d_pc  [3];

  ent_t mq [3][$];
  int   rr;
  logic [BUS_WIDTH-1:0] e_b0, e_b1;
  logic        e_mv;
  logic [31:0] e_mres;
  logic [5:0]  e_mrob;
  logic [2:0]  e_rdy;
  int n_cmp = 0, n_bad = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_mem(src_mem), .src_res(src_res), .src_rd(src_rd),
    .src_rob(src_rob), .src_pc(src_pc), .src_ready(src_ready),
    .bus0(bus0), .bus1(bus1),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_res(mem_res), .mem_rob(mem_rob)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mq[i].delete();
    rr = 0;
    e_b0 = '0; e_b1 = '0; e_mv = 0; e_mres = '0; e_mrob = '0; e_rdy = 3'b111;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 3; i++) begin
      d_res[i] = $urandom;
      d_rd[i]  = 6'($urandom);
      d_rob[i] = 6'($urandom);
      d_pc[i]  = 12'($urandom);
    end
  endtask

  // Drives one cycle of stimulus (valid masked by the model's ready, like a stalling ALU),
  // advances the reference model across the edge, and returns at the following negedge.
  task automatic step(input logic [2:0] v, input logic [2:0] m, input logic mr, input logic fl);
    logic [2:0] vv, rdy0;
    int b0, b1, ms, s;
    ent_t e;
    rdy0 = e_rdy;
    vv = fl ? v : (v & e_rdy);
    src_valid = vv; src_mem = m; mem_ready = mr; flush = fl;
    src_res = {d_res[2], d_res[1], d_res[0]};
    src_rd  = {d_rd[2], d_rd[1], d_rd[0]};
    src_rob = {d_rob[2], d_rob[1], d_rob[0]};
    src_pc  = {d_pc[2], d_pc[1], d_pc[0]};
    @(posedge clk);
    e_b0 = '0; e_b1 = '0; e_mv = 0; e_mres = '0; e_mrob = '0;
    if (fl) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      rr = 0;
    end else begin
      b0 = -1; b1 = -1; ms = -1;
      for (int k = 0; k < 3; k++) begin
        s = (rr + k) % 3;
        if (mq[s].size() == 0) continue;
        if (mq[s][0].mem) begin
          if (ms < 0) ms = s;
        end else if (b0 < 0) b0 = s;
        else if (b1 < 0) b1 = s;
      end
      if (b0 >= 0) begin e = mq[b0].pop_front(); e_b0 = {1'b1, e.pc, e.res, e.rd, e.rob}; rr = (b0 + 1) % 3; end
      if (b1 >= 0) begin e = mq[b1].pop_front(); e_b1 = {1'b1, e.pc, e.res, e.rd, e.rob}; rr = (b1 + 1) % 3; end
      if (ms >= 0 && mr) begin e = mq[ms].pop_front(); e_mv = 1; e_mres = e.res; e_mrob = e.rob; end
      for (int i = 0; i < 3; i++)
        if (vv[i] && rdy0[i]) begin
          e.mem = m[i]; e.pc = d_pc[i]; e.res = d_res[i]; e.rd = d_rd[i]; e.rob = d_rob[i];
          mq[i].push_back(e);
        end
    end
    for (int i = 0; i < 3; i++) e_rdy[i] = mq[i].size() < DEPTH;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_clear();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus0 !== '0) begin n_bad++; $display("FAIL reset_bus0: got %h expected 0", bus0); end
    n_cmp++; if (bus1 !== '0) begin n_bad++; $display("FAIL reset_bus1: got %h expected 0", bus1); end
    n_cmp++; if ({mem_valid, mem_res, mem_rob} !== '0) begin n_bad++; $display("FAIL reset_mem: got %b/%h/%h expected zeros", mem_valid, mem_res, mem_rob); end
    rst = 0;
    @(negedge clk);
    n_cmp++; if (src_ready !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b expected 111", src_ready); end
  endtask

  task automatic test_single();
    rand_data();
    d_res[1] = 32'h0000_00AA; d_rd[1] = 6'd5; d_rob[1] = 6'd3; d_pc[1] = 12'h010;
    step(3'b010, 3'b000, 1, 0);
    n_cmp++; if (bus0[BUS_VALID] !== 1'b0) begin n_bad++; $display("FAIL single_early: bus0 valid got %b expected 0", bus0[BUS_VALID]); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if (bus0 !== {1'b1, 12'h010, 32'h0000_00AA, 6'd5, 6'd3}) begin n_bad++; $display("FAIL single_bus0: got %h expected %h", bus0, {1'b1, 12'h010, 32'h0000_00AA, 6'd5, 6'd3}); end
    n_cmp++; if (bus1[BUS_VALID] !== 1'b0) begin n_bad++; $display("FAIL single_bus1: valid got %b expected 0", bus1[BUS_VALID]); end
  endtask

  task automatic test_triple();
    step(3'b000, 3'b000, 1, 1);
    rand_data();
    d_rob[0] = 6'd10; d_rob[1] = 6'd11; d_rob[2] = 6'd12;
    step(3'b111, 3'b000, 1, 0);
    rand_data();
    d_rob[0] = 6'd20; d_rob[1] = 6'd21;
    step(3'b011, 3'b000, 1, 0);
    n_cmp++; if ({bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID], bus1[5:0]} !== {1'b1, 6'd10, 1'b1, 6'd11}) begin
      n_bad++; $display("FAIL triple_c1: got b0 %b/%0d b1 %b/%0d expected 1/10 1/11", bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID], bus1[5:0]); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID], bus1[5:0]} !== {1'b1, 6'd12, 1'b1, 6'd20}) begin
      n_bad++; $display("FAIL triple_c2: got b0 %b/%0d b1 %b/%0d expected 1/12 1/20", bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID], bus1[5:0]); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID]} !== {1'b1, 6'd21, 1'b0}) begin
      n_bad++; $display("FAIL triple_c3: got b0 %b/%0d b1 %b expected 1/21 0", bus0[BUS_VALID], bus0[5:0], bus1[BUS_VALID]); end
    n_cmp++; if ({bus0, bus1, mem_valid, src_ready} !== {e_b0, e_b1, e_mv, e_rdy}) begin
      n_bad++; $display("FAIL triple_model: got %h %h %b %b expected %h %h %b %b", bus0, bus1, mem_valid, src_ready, e_b0, e_b1, e_mv, e_rdy); end
  endtask

  task automatic test_backpressure();
    logic [5:0] sent[$], got[$];
    int seq;
    logic full, ok;
    step(3'b000, 3'b000, 1, 1);
    seq = 0; full = 0;
    for (int c = 0; c < 16; c++) begin
      rand_data();
      d_rob[0] = {2'b00, 4'(seq)}; d_rob[1] = {2'b01, 4'(c)}; d_rob[2] = {2'b10, 4'(c)};
      if (c < 10 && e_rdy[0]) begin sent.push_back(d_rob[0]); seq++; end
      step(c < 10 ? 3'b111 : 3'b000, 3'b000, 1, 0);
      if (!src_ready[0]) full = 1;
      if (bus0[BUS_VALID] && bus0[5:4] == 2'b00) got.push_back(bus0[5:0]);
      if (bus1[BUS_VALID] && bus1[5:4] == 2'b00) got.push_back(bus1[5:0]);
      n_cmp++; if ({bus0, bus1, src_ready} !== {e_b0, e_b1, e_rdy}) begin
        n_bad++; $display("FAIL backpressure[%0d]: got %h %h rdy=%b expected %h %h rdy=%b", c, bus0, bus1, src_ready, e_b0, e_b1, e_rdy); end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL backpressure_full: src_ready[0] low seen=%b expected 1", full); end
    ok = (got.size() == sent.size());
    for (int i = 0; i < got.size() && ok; i++) if (got[i] !== sent[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL backpressure_order: got %0d alu0 results expected %0d in order", got.size(), sent.size()); end
  endtask

  task automatic test_mem();
    step(3'b000, 3'b000, 1, 1);
    rand_data(); d_rob[2] = 6'd40;
    step(3'b100, 3'b100, 0, 0);
    rand_data(); d_rob[2] = 6'd41;
    step(3'b100, 3'b100, 0, 0);
    n_cmp++; if ({mem_valid, src_ready[2]} !== 2'b00) begin n_bad++; $display("FAIL mem_hold: got mv=%b rdy2=%b expected 0 0", mem_valid, src_ready[2]); end
    rand_data(); d_rob[0] = 6'd42;
    step(3'b001, 3'b000, 0, 0);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL mem_notready: got mv=%b expected 0", mem_valid); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({mem_valid, mem_rob, bus0[BUS_VALID], bus0[5:0]} !== {1'b1, 6'd40, 1'b1, 6'd42}) begin
      n_bad++; $display("FAIL mem_grant: got mv=%b rob=%0d b0 %b/%0d expected 1/40 1/42", mem_valid, mem_rob, bus0[BUS_VALID], bus0[5:0]); end
    n_cmp++; if ({mem_res, src_ready} !== {e_mres, e_rdy}) begin n_bad++; $display("FAIL mem_res: got %h rdy=%b expected %h rdy=%b", mem_res, src_ready, e_mres, e_rdy); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({mem_valid, mem_rob} !== {1'b1, 6'd41}) begin n_bad++; $display("FAIL mem_second: got mv=%b rob=%0d expected 1/41", mem_valid, mem_rob); end
  endtask

  task automatic test_flush();
    rand_data(); step(3'b111, 3'b001, 0, 0);
    rand_data(); step(3'b111, 3'b001, 0, 0);
    rand_data(); step(3'b010, 3'b000, 1, 1);
    n_cmp++; if ({bus0, bus1, mem_valid, mem_res, mem_rob, src_ready} !== {{(2*BUS_WIDTH+39){1'b0}}, 3'b111}) begin
      n_bad++; $display("FAIL flush_out: got %h %h %b %h %h rdy=%b expected zeros rdy=111", bus0, bus1, mem_valid, mem_res, mem_rob, src_ready); end
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({bus0[BUS_VALID], bus1[BUS_VALID], mem_valid} !== 3'b000) begin
      n_bad++; $display("FAIL flush_noenq: got valids %b%b%b expected 000", bus0[BUS_VALID], bus1[BUS_VALID], mem_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rand_data();
      step(3'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 19) == 0);
      n_cmp++; if ({bus0, bus1, mem_valid, mem_res, mem_rob, src_ready} !== {e_b0, e_b1, e_mv, e_mres, e_mrob, e_rdy}) begin
        n_bad++; $display("FAIL random[%0d]: got b0=%h b1=%h m=%b/%h/%h rdy=%b expected b0=%h b1=%h m=%b/%h/%h rdy=%b",
                          c, bus0, bus1, mem_valid, mem_res, mem_rob, src_ready, e_b0, e_b1, e_mv, e_mres, e_mrob, e_rdy); end
    end
  endtask

  task automatic test_async_reset();
    rand_data(); step(3'b111, 3'b000, 1, 0);
    rand_data(); step(3'b111, 3'b100, 0, 0);
    #2 rst = 1;
    #1;
    n_cmp++; if ({bus0, bus1, mem_valid, mem_res, mem_rob, src_ready} !== {{(2*BUS_WIDTH+39){1'b0}}, 3'b111}) begin
      n_bad++; $display("FAIL async_reset: got %h %h %b %h %h rdy=%b expected zeros rdy=111", bus0, bus1, mem_valid, mem_res, mem_rob, src_ready); end
    @(negedge clk);
    rst = 0;
    model_clear();
    step(3'b000, 3'b000, 1, 0);
    n_cmp++; if ({bus0, bus1, mem_valid, src_ready} !== {e_b0, e_b1, e_mv, e_rdy}) begin
      n_bad++; $display("FAIL async_empty: got %h %h %b rdy=%b expected %h %h %b rdy=%b", bus0, bus1, mem_valid, src_ready, e_b0, e_b1, e_mv, e_rdy); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin d_res[i] = 0; d_rd[i] = 0; d_rob[i] = 0; d_pc[i] = 0; end
    test_reset();
    test_single();
    test_triple();
    test_backpressure();
    test_mem();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
